// File: rtl/dma_axi_arbiter.sv
// Scratchpad port arbiter: vector DMA owns the port by default, AXI bridge
// takes it for whole read/write bursts; read ownership follows the memory pipe.
module dma_axi_arbiter #(
  parameter int ADDRWIDTH = 11,
  parameter int NUMLANES  = 8,
  parameter int WIDTH     = 16,
  parameter int MEMLAT    = 1,
  parameter int LENW      = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUMLANES*ADDRWIDTH-1:0] dma_addr,
  input  logic [NUMLANES*WIDTH-1:0]     dma_data,
  input  logic [NUMLANES-1:0]           dma_rden,
  input  logic [NUMLANES-1:0]           dma_wren,
  output logic                          dma_stall,
  output logic [NUMLANES*WIDTH-1:0]     dma_out,
  output logic [NUMLANES-1:0]           dma_rvalid,
  input  logic                          axi_req_valid,
  output logic                          axi_req_ready,
  input  logic                          axi_req_type,
  input  logic [ADDRWIDTH-1:0]          axi_addr,
  input  logic [LENW-1:0]               axi_len,
  input  logic [NUMLANES*WIDTH-1:0]     axi_wdata,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [NUMLANES*WIDTH-1:0]     axi_rdata,
  output logic                          axi_rvalid,
  output logic [NUMLANES*ADDRWIDTH-1:0] mem_addr,
  output logic [NUMLANES*WIDTH-1:0]     mem_data,
  output logic [NUMLANES-1:0]           mem_rden,
  output logic [NUMLANES-1:0]           mem_wren,
  input  logic [NUMLANES*WIDTH-1:0]     mem_readdata
);

  typedef enum logic [1:0] {
    IDLE,
    AXI_RD,
    AXI_WR
  } state_t;

  state_t                          state;
  logic [ADDRWIDTH-1:0]            cur_addr;
  logic [LENW-1:0]                 remaining;
  logic [NUMLANES:0]               tag_q [MEMLAT];
  logic [NUMLANES:0]               tag_in;
  logic [NUMLANES*ADDRWIDTH-1:0]   lane_addr;
  logic                            beat;
  logic                            last;

  always_comb begin
    lane_addr = '0;
    for (int l = 0; l < NUMLANES; l++)
      lane_addr[l*ADDRWIDTH +: ADDRWIDTH] = cur_addr + ADDRWIDTH'(l);
  end

  always_comb begin
    beat = 1'b0;
    if (state == AXI_RD)
      beat = 1'b1;
    else if (state == AXI_WR)
      beat = axi_wvalid;
    last = (remaining == '0);
  end

  // Tag = {axi read, per-lane dma read} of the cycle's issued access
  always_comb begin
    tag_in = '0;
    if (state == AXI_RD)
      tag_in[NUMLANES] = 1'b1;
    else if (state == IDLE)
      tag_in[NUMLANES-1:0] = dma_rden;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      for (int i = 0; i < MEMLAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MEMLAT; i++)
        tag_q[i] <= tag_q[i-1];
      unique case (state)
        IDLE: begin
          if (axi_req_valid) begin
            cur_addr  <= axi_addr;
            remaining <= axi_len;
            state     <= axi_req_type ? AXI_WR : AXI_RD;
          end
        end
        AXI_RD, AXI_WR: begin
          if (beat) begin
            cur_addr  <= cur_addr + ADDRWIDTH'(NUMLANES);
            remaining <= remaining - LENW'(1);
            if (last)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dma_stall     = 1'b1;
    axi_req_ready = 1'b0;
    axi_wready    = 1'b0;
    mem_addr      = '0;
    mem_data      = '0;
    mem_rden      = '0;
    mem_wren      = '0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          dma_stall     = 1'b0;
          axi_req_ready = 1'b1;
          mem_addr      = dma_addr;
          mem_data      = dma_data;
          mem_rden      = dma_rden;
          mem_wren      = dma_wren;
        end
        AXI_RD: begin
          mem_addr = lane_addr;
          mem_rden = '1;
        end
        AXI_WR: begin
          axi_wready = 1'b1;
          if (axi_wvalid) begin
            mem_addr = lane_addr;
            mem_data = axi_wdata;
            mem_wren = '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign axi_rvalid = resetn & tag_q[MEMLAT-1][NUMLANES];
  assign dma_rvalid = resetn ? tag_q[MEMLAT-1][NUMLANES-1:0] : '0;
  assign axi_rdata  = mem_readdata;
  assign dma_out    = mem_readdata;

endmodule

// File: tb/tb_dma_axi_arbiter.sv
// Directed bench for dma_axi_arbiter with a scratchpad model and a
// scoreboard of expected AXI read beats.
module tb_dma_axi_arbiter;
  localparam int AW = 11;
  localparam int NL = 8;
  localparam int W  = 16;
  localparam int ML = 2;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NL*AW-1:0] dma_addr, mem_addr;
  logic [NL*W-1:0]  dma_data, dma_out, mem_data, mem_readdata;
  logic [NL-1:0]    dma_rden, dma_wren, dma_rvalid, mem_rden, mem_wren;
  logic             dma_stall;
  logic             axi_req_valid, axi_req_ready, axi_req_type;
  logic [AW-1:0]    axi_addr;
  logic [LW-1:0]    axi_len;
  logic [NL*W-1:0]  axi_wdata, axi_rdata;
  logic             axi_wvalid, axi_wready, axi_rvalid;

  int nvec = 0;
  int nerr = 0;

  dma_axi_arbiter #(
    .ADDRWIDTH(AW), .NUMLANES(NL), .WIDTH(W), .MEMLAT(ML), .LENW(LW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_rden(dma_rden), .dma_wren(dma_wren),
    .dma_stall(dma_stall), .dma_out(dma_out), .dma_rvalid(dma_rvalid),
    .axi_req_valid(axi_req_valid), .axi_req_ready(axi_req_ready),
    .axi_req_type(axi_req_type), .axi_addr(axi_addr), .axi_len(axi_len),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Scratchpad model: hashed background contents plus a write overlay
  bit   [W-1:0]    ov [NL][2048];
  logic [NL*W-1:0] rp [ML];
  assign mem_readdata = rp[ML-1];

  function automatic logic [W-1:0] hashv(int l, logic [AW-1:0] a);
    return W'(l * 2048 + int'(a)) ^ 16'h5A3C;
  endfunction

  function automatic logic [W-1:0] cont(int l, logic [AW-1:0] a);
    return hashv(l, a) ^ ov[l][a];
  endfunction

  function automatic logic [NL*W-1:0] rdbeat();
    logic [NL*W-1:0] r = '0;
    for (int l = 0; l < NL; l++)
      if (mem_rden[l]) r[l*W +: W] = cont(l, mem_addr[l*AW +: AW]);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++)
      if (mem_wren[l])
        ov[l][mem_addr[l*AW +: AW]] <=
          mem_data[l*W +: W] ^ hashv(l, mem_addr[l*AW +: AW]);
    rp[0] <= rdbeat();
    for (int i = 1; i < ML; i++) rp[i] <= rp[i-1];
  end

  function automatic logic [NL*AW-1:0] lanes(logic [AW-1:0] b);
    logic [NL*AW-1:0] r = '0;
    for (int l = 0; l < NL; l++) r[l*AW +: AW] = b + AW'(l);
    return r;
  endfunction

  function automatic logic [NL*W-1:0] burst_exp(logic [AW-1:0] b);
    logic [NL*W-1:0] r = '0;
    for (int l = 0; l < NL; l++) r[l*W +: W] = cont(l, b + AW'(l));
    return r;
  endfunction

  function automatic logic [NL*W-1:0] dma_exp(logic [AW-1:0] a, logic [NL-1:0] m);
    logic [NL*W-1:0] r = '0;
    for (int l = 0; l < NL; l++) if (m[l]) r[l*W +: W] = cont(l, a);
    return r;
  endfunction

  logic [NL*W-1:0] axq [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [AW-1:0] b, input int len);
    for (int k = 0; k <= len; k++) axq.push_back(burst_exp(b + AW'(k * NL)));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (axi_rvalid === 1'b1) begin
      if (axq.size() == 0) chk("rd_unexpected", 128'(axi_rvalid), 128'(0));
      else chk("rd_data", 128'(axi_rdata), 128'(axq.pop_front()));
    end
  end

  initial begin
    logic [AW-1:0] b;
    logic [5:0]    pat;
    logic [7:0]    e_rdy, e_stl, e_arv, e_drv;
    int            nw, wcnt;

    resetn = 1'b0; dma_addr = '0; dma_data = '0; dma_rden = '1; dma_wren = '0;
    axi_req_valid = 1'b1; axi_req_type = 1'b0; axi_addr = '0; axi_len = '0;
    axi_wdata = '0; axi_wvalid = 1'b0;
    smp();
    chk("rst_req_ready", 128'(axi_req_ready), 128'(0));
    chk("rst_wready", 128'(axi_wready), 128'(0));
    chk("rst_stall", 128'(dma_stall), 128'(1));
    chk("rst_rden", 128'(mem_rden), 128'(0));
    chk("rst_wren", 128'(mem_wren), 128'(0));
    chk("rst_rvalid", 128'({axi_rvalid, dma_rvalid}), 128'(0));
    nxt();
    nxt(); resetn = 1'b1; dma_rden = '0; axi_req_valid = 1'b0;

    // DMA pass-through read
    nxt(); dma_rden = 8'hFF; dma_addr = {NL{11'h010}};
    smp();
    chk("idle_rden", 128'(mem_rden), 128'(8'hFF));
    chk("idle_addr", 128'(mem_addr), 128'({NL{11'h010}}));
    chk("idle_stall", 128'(dma_stall), 128'(0));
    chk("idle_ready", 128'(axi_req_ready), 128'(1));
    nxt(); dma_rden = '0;
    smp(); chk("dma_rv_early", 128'(dma_rvalid), 128'(0));
    nxt(); smp();
    chk("dma_rv", 128'(dma_rvalid), 128'(8'hFF));
    chk("dma_out", 128'(dma_out), 128'(dma_exp(11'h010, 8'hFF)));
    chk("dma_no_axi_rv", 128'(axi_rvalid), 128'(0));

    // AXI read burst wrapping the address space
    nxt(); axi_req_valid = 1'b1; axi_req_type = 1'b0; axi_addr = 11'h7F8; axi_len = 8'd2;
    smp();
    chk("wrap_accept", 128'(axi_req_ready), 128'(1));
    push_rd(11'h7F8, 2);
    for (int k = 1; k <= 6; k++) begin
      nxt(); axi_req_valid = 1'b0;
      smp();
      if (k <= 3) begin
        b = 11'h7F8 + AW'(8 * (k - 1));
        chk("wrap_stall", 128'(dma_stall), 128'(1));
        chk("wrap_rden", 128'(mem_rden), 128'(8'hFF));
        chk("wrap_wren", 128'(mem_wren), 128'(0));
        chk("wrap_addr", 128'(mem_addr), 128'(lanes(b)));
        chk("wrap_data0", 128'(mem_data), 128'(0));
        chk("wrap_ready", 128'(axi_req_ready), 128'(0));
      end else begin
        chk("wrap_end_stall", 128'(dma_stall), 128'(0));
        chk("wrap_end_ready", 128'(axi_req_ready), 128'(1));
      end
      chk("wrap_rvalid", 128'(axi_rvalid), 128'(k >= 3 && k <= 5));
    end

    // AXI write burst with wvalid gaps
    nxt(); axi_req_valid = 1'b1; axi_req_type = 1'b1; axi_addr = 11'h100; axi_len = 8'd3;
    smp(); chk("wr_accept", 128'(axi_req_ready), 128'(1));
    pat = 6'b111001; nw = 0; wcnt = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); axi_req_valid = 1'b0; axi_wvalid = pat[i];
      axi_wdata = {$urandom, $urandom, $urandom, $urandom};
      smp();
      chk("wr_wready", 128'(axi_wready), 128'(1));
      chk("wr_stall", 128'(dma_stall), 128'(1));
      if (mem_wren == 8'hFF) wcnt++;
      if (pat[i]) begin
        chk("wr_wren", 128'(mem_wren), 128'(8'hFF));
        chk("wr_data", 128'(mem_data), 128'(axi_wdata));
        chk("wr_addr", 128'(mem_addr), 128'(lanes(11'h100 + AW'(8 * nw))));
        nw++;
      end else begin
        chk("gap_wren", 128'(mem_wren), 128'(0));
        chk("gap_rden", 128'(mem_rden), 128'(0));
        chk("gap_addr", 128'(mem_addr), 128'(0));
      end
    end
    nxt(); axi_wvalid = 1'b0;
    smp();
    chk("wr_beats", 128'(wcnt), 128'(4));
    chk("wr_end_wready", 128'(axi_wready), 128'(0));
    chk("wr_end_stall", 128'(dma_stall), 128'(0));
    chk("wr_end_ready", 128'(axi_req_ready), 128'(1));

    // Back-to-back reads with DMA reads in the accept cycles
    e_rdy = 8'b11001001; e_stl = 8'b00110110;
    e_arv = 8'b11011000; e_drv = 8'b00100100;
    dma_addr = {NL{11'h300}};
    for (int k = 0; k < 8; k++) begin
      nxt();
      axi_req_valid = (k <= 3); axi_req_type = 1'b0; axi_len = 8'd1;
      axi_addr = (k < 3) ? 11'h200 : 11'h210;
      dma_rden = (k <= 5) ? 8'h0F : 8'h00;
      smp();
      if (k == 0) push_rd(11'h200, 1);
      if (k == 3) push_rd(11'h210, 1);
      chk("b2b_ready", 128'(axi_req_ready), 128'(e_rdy[k]));
      chk("b2b_stall", 128'(dma_stall), 128'(e_stl[k]));
      chk("b2b_axi_rv", 128'(axi_rvalid), 128'(e_arv[k]));
      chk("b2b_dma_rv", 128'(dma_rvalid), 128'(e_drv[k] ? 8'h0F : 8'h00));
      if (k == 0 || k == 3) begin
        chk("b2b_pass_rden", 128'(mem_rden), 128'(8'h0F));
        chk("b2b_pass_addr", 128'(mem_addr), 128'({NL{11'h300}}));
      end
      if (e_drv[k]) chk("b2b_dma_out", 128'(dma_out), 128'(dma_exp(11'h300, 8'h0F)));
    end

    // Reset during the second beat of a read
    nxt(); axi_req_valid = 1'b1; axi_addr = 11'h400; axi_len = 8'd3;
    smp(); chk("rstmid_accept", 128'(axi_req_ready), 128'(1));
    nxt(); axi_req_valid = 1'b0;
    smp(); chk("rstmid_beat1", 128'(mem_rden), 128'(8'hFF));
    nxt(); resetn = 1'b0;
    smp();
    chk("rstmid_ready", 128'(axi_req_ready), 128'(0));
    chk("rstmid_rden", 128'(mem_rden), 128'(0));
    chk("rstmid_stall", 128'(dma_stall), 128'(1));
    for (int k = 0; k < 4; k++) begin
      nxt(); resetn = 1'b1;
      smp();
      chk("rstmid_no_rv", 128'(axi_rvalid), 128'(0));
      if (k == 0) begin
        chk("rstmid_idle_ready", 128'(axi_req_ready), 128'(1));
        chk("rstmid_idle_stall", 128'(dma_stall), 128'(0));
        chk("rstmid_idle_rden", 128'(mem_rden), 128'(0));
      end
    end

    // Read back the written region, then a single-beat wrapping read
    nxt(); axi_req_valid = 1'b1; axi_addr = 11'h100; axi_len = 8'd3;
    smp(); chk("rb_accept", 128'(axi_req_ready), 128'(1));
    push_rd(11'h100, 3);
    nxt(); axi_req_valid = 1'b0;
    repeat (3) nxt();
    nxt(); axi_req_valid = 1'b1; axi_addr = 11'h7FF; axi_len = 8'd0;
    smp(); chk("one_accept", 128'(axi_req_ready), 128'(1));
    push_rd(11'h7FF, 0);
    nxt(); axi_req_valid = 1'b0;
    smp();
    chk("one_rden", 128'(mem_rden), 128'(8'hFF));
    chk("one_addr", 128'(mem_addr), 128'(lanes(11'h7FF)));
    nxt(); smp();
    chk("one_end_stall", 128'(dma_stall), 128'(0));
    chk("one_end_ready", 128'(axi_req_ready), 128'(1));
    chk("one_end_rden", 128'(mem_rden), 128'(0));
    repeat (4) nxt();
    smp();
    chk("scoreboard_drained", 128'(axq.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dma_axi_arbiter.md
# dma_axi_arbiter

- Parametrised, sequential successor to the vector-scratchpad DMA/AXI port mux.
- Arbitrates one banked scratchpad port (NUMLANES lanes, one word per lane per cycle) between two masters:
  - the vector DMA lane port, which owns the memory by default;
  - an AXI-side bridge that issues multi-beat read/write bursts through a ready/valid handshake.
- Tracks read ownership through the memory latency pipe, so read data returns to the master that issued it, and actually delivers AXI read data.

## Interface
- ADDRWIDTH, 11, per-lane scratchpad address width
- NUMLANES, 8, lane count; one beat = NUMLANES words
- WIDTH, 16, word width per lane
- MEMLAT, 1, scratchpad read latency in cycles (legal 1..4)
- LENW, 8, burst length field width
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- dma_addr  in  NUMLANES*ADDRWIDTH  per-lane DMA address
- dma_data  in  NUMLANES*WIDTH  DMA write data
- dma_rden / dma_wren  in  NUMLANES each  per-lane DMA read/write enables
- dma_stall  out  1  DMA must hold its request; the request is not applied this cycle
- dma_out  out  NUMLANES*WIDTH  read data to DMA (= mem_readdata)
- dma_rvalid  out  NUMLANES  per-lane DMA read data valid
- axi_req_valid / axi_req_ready  in/out  1  burst request handshake
- axi_req_type  in  1  1 = write, 0 = read
- axi_addr  in  ADDRWIDTH  burst base address
- axi_len  in  LENW  beats minus one
- axi_wdata  in  NUMLANES*WIDTH  write beat data
- axi_wvalid / axi_wready  in/out  1  write beat handshake
- axi_rdata  out  NUMLANES*WIDTH  read beat data
- axi_rvalid  out  1  read beat valid; there is no backpressure, so the bridge must accept every beat
- mem_addr, mem_data, mem_rden, mem_wren  out  widths as DMA side  scratchpad port
- mem_readdata  in  NUMLANES*WIDTH  scratchpad read data, MEMLAT cycles after rden

## Operation
- State machine: IDLE, AXI_RD, AXI_WR.
- IDLE:
  - mem_* = dma_* pass-through; dma_stall=0; axi_req_ready=1.
  - axi_req_valid&axi_req_ready latches base address into cur_addr, axi_len into remaining beat count, and type.
  - Goes to AXI_RD or AXI_WR.
  - The DMA still owns memory in the accept cycle.
- AXI_RD:
  - dma_stall=1; every cycle issues one beat: mem_rden=all ones, mem_wren=0.
  - Lane l address = cur_addr + l, modulo 2^ADDRWIDTH.
  - After each beat: cur_addr += NUMLANES (wraps); count decrements.
  - Returns to IDLE after beat axi_len+1.
- AXI_WR:
  - dma_stall=1; axi_wready=1.
  - On axi_wvalid: mem_wren=all ones, mem_data=axi_wdata, same addressing and advance as reads.
  - Without axi_wvalid: mem_rden=mem_wren=0 and the state holds.
  - Returns to IDLE after the last accepted beat.
- Ownership tag pipe:
  - MEMLAT-deep shift register carrying {axi_rd, dma_rden[NUMLANES]} of each issued cycle.
  - axi_rvalid = axi tag at output; dma_rvalid = DMA tag at output.
  - axi_rdata = dma_out = mem_readdata.
- Fairness: after any burst ends, at least one IDLE cycle is granted to the DMA before the next accept.
- Outputs during DMA-owned cycles with no access: mem_rden=mem_wren=0 per the DMA inputs. Outputs not being driven by the owning master are zero: mem_data in AXI_RD, mem_addr=0 when AXI_WR is waiting for wvalid.

## Timing
- While resetn=0:
  - axi_req_ready=0, axi_wready=0, dma_stall=1;
  - mem_rden=0, mem_wren=0; axi_rvalid=0, dma_rvalid=0.
  - Next edge: state=IDLE, counters=0, tag pipe cleared.
- Reset mid-burst aborts the burst. In-flight reads produce no rvalid on either side.
- A request accepted at edge T issues its first beat in cycle T+1. A read burst occupies cycles T+1..T+1+axi_len.
- Read data: a beat issued in cycle C has rvalid in cycle C+MEMLAT.
- Burst of 1 beat (axi_len=0): one AXI cycle, then IDLE.
- A DMA read issued in the accept cycle returns as dma_rvalid even if an AXI burst is then active. The tag pipe is owner-exact, so no drain state is needed.
- cur_addr and per-lane addition are ADDRWIDTH bits; carries are discarded.

## Test plan
- Idle pass-through, MEMLAT=2: dma_rden=8'hFF, all lane addrs 0x010 in cycle 0.
  - mem_rden=8'hFF and mem_addr lane fields 0x010 in cycle 0.
  - dma_rvalid=8'hFF in cycle 2; axi_rvalid stays 0.
- AXI read wrap: accept at T with addr=0x7F8, len=2.
  - Beats at T+1..T+3, dma_stall=1 throughout.
  - Lane0 addrs 0x7F8, 0x000, 0x008; lane7 addrs 0x7FF, 0x007, 0x00F.
  - With MEMLAT=2, axi_rvalid is high T+3..T+5 with matching data.
- AXI write with gaps: len=3, wvalid pattern 1,0,0,1,1,1.
  - Exactly 4 mem_wren=all-ones cycles with the corresponding wdata.
  - axi_wready stays 1 through the gaps; IDLE follows the 4th beat.
- Back-to-back: axi_req_valid held high across two len=1 reads.
  - axi_req_ready=0 during the first burst.
  - Exactly one IDLE cycle with DMA pass-through between the bursts.
- Reset mid-read: resetn=0 during the 2nd beat of a len=3 read.
  - Next cycle: state IDLE, no axi_rvalid for the aborted beats, axi_req_ready=1 once resetn=1.
- Mixed ownership: DMA read in the accept cycle of an AXI read burst.
  - dma_rvalid asserts MEMLAT cycles later; the AXI beats return only on axi_rvalid.
